// File: rtl/itrx_amba3_ahblite_regbank_slv_if.sv
// AHB-Lite bus bundle for one slave port.
// Master drives address/control/wdata and the bus-level hready.
interface itrx_amba3_ahblite_regbank_slv_if #(
  parameter int HDATAW = 64
);
  logic              hsel;
  logic [31:0]       haddr;
  logic [1:0]        htrans;
  logic              hwrite;
  logic [2:0]        hsize;
  logic [2:0]        hburst;
  logic [3:0]        hprot;
  logic              hmastlock;
  logic [HDATAW-1:0] hwdata;
  logic              hready;
  logic              hreadyout;
  logic              hresp;
  logic [HDATAW-1:0] hrdata;

  modport master (
    output hsel, haddr, htrans, hwrite, hsize,
    output hburst, hprot, hmastlock, hwdata, hready,
    input  hreadyout, hresp, hrdata
  );

  modport slave (
    input  hsel, haddr, htrans, hwrite, hsize,
    input  hburst, hprot, hmastlock, hwdata, hready,
    output hreadyout, hresp, hrdata
  );
endinterface

// File: rtl/itrx_amba3_ahblite_regbank_slv.sv
// AHB-Lite register-bank slave: wait states, byte-lane writes,
// two-cycle ERROR on unaligned, oversize or out-of-range access.
module itrx_amba3_ahblite_regbank_slv #(
  parameter int HDATAW = 64,
  parameter int NWORDS = 16,
  parameter int WAIT   = 0
) (
  input logic hclk,
  input logic hreset_n,
  itrx_amba3_ahblite_regbank_slv_if.slave bus
);
  localparam int BYTES = HDATAW / 8;
  localparam int AW    = $clog2(BYTES);
  localparam int IW    = $clog2(NWORDS);
  localparam logic [31:0] RANGE = 32'(NWORDS * BYTES);
  localparam logic [2:0]  MAXSZ = 3'(AW);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAITST = 2'd1,
    ERR1   = 2'd2,
    ERR2   = 2'd3
  } state_e;

  state_e state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic act_q, act_d;
  logic wr_q;
  logic [2:0] size_q;
  logic [IW-1:0] word_q;
  logic [AW-1:0] lane_q;
  logic [HDATAW-1:0] bank [NWORDS];

  logic open, sample, err, commit, rd_en;
  logic [2:0] amask;
  logic [BYTES-1:0] be;
  logic unused;

  assign unused = ^{bus.hburst, bus.hprot,
                    bus.hmastlock, bus.htrans[0]};

  // Ready in IDLE and ERR2, so only those states accept an address
  assign open   = (state_q == IDLE) || (state_q == ERR2);
  assign sample = open & bus.hsel & bus.hready & bus.htrans[1];

  // Low-address mask that must be zero for the requested size
  always_comb begin
    amask = 3'b000;
    unique case (1'b1)
      (bus.hsize == 3'd1): amask = 3'b001;
      (bus.hsize == 3'd2): amask = 3'b011;
      (bus.hsize == 3'd3): amask = 3'b111;
      default:             amask = 3'b000;
    endcase
  end

  assign err = (bus.haddr >= RANGE)
             | (bus.hsize > MAXSZ)
             | (|(bus.haddr[2:0] & amask));

  // Next-state logic: wait countdown and two-cycle error response
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    act_d   = act_q;
    unique case (state_q)
      IDLE, ERR2: begin
        state_d = IDLE;
        act_d   = sample & ~err;
        if (sample) begin
          if (err) begin
            state_d = ERR1;
          end else if (WAIT > 0) begin
            state_d = WAITST;
            cnt_d   = 3'(WAIT - 1);
          end
        end
      end
      WAITST: begin
        if (cnt_q == 3'd0) state_d = IDLE;
        else cnt_d = cnt_q - 3'd1;
      end
      ERR1: state_d = ERR2;
      default: state_d = IDLE;
    endcase
  end

  // FSM state and captured address-phase fields
  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      act_q   <= 1'b0;
      wr_q    <= 1'b0;
      size_q  <= 3'd0;
      word_q  <= '0;
      lane_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      act_q   <= act_d;
      if (sample) begin
        wr_q   <= bus.hwrite;
        size_q <= bus.hsize;
        word_q <= bus.haddr[AW +: IW];
        lane_q <= bus.haddr[AW-1:0];
      end
    end
  end

  // Completing cycle is IDLE with an OKAY transfer still open
  assign commit = (state_q == IDLE) & act_q & wr_q;
  assign rd_en  = (state_q == IDLE) & act_q & ~wr_q;

  // Little-endian byte enables from size and low address
  always_comb begin
    be = '0;
    for (int b = 0; b < BYTES; b++) begin
      if (b >= int'(lane_q) &&
          b < int'(lane_q) + (1 << size_q))
        be[b] = 1'b1;
    end
  end

  // Register bank with per-byte write strobes
  always_ff @(posedge hclk or negedge hreset_n) begin
    if (!hreset_n) begin
      for (int w = 0; w < NWORDS; w++) bank[w] <= '0;
    end else if (commit) begin
      for (int b = 0; b < BYTES; b++)
        if (be[b]) bank[word_q][8*b +: 8] <= bus.hwdata[8*b +: 8];
    end
  end

  assign bus.hreadyout = (state_q == IDLE) || (state_q == ERR2);
  assign bus.hresp     = (state_q == ERR1) || (state_q == ERR2);
  assign bus.hrdata    = rd_en ? bank[word_q] : '0;
endmodule

// File: tb/tb_itrx_amba3_ahblite_regbank_slv.sv
// Directed bench: three slaves with WAIT=0, 2 and 3 share one
// master; each slave's hready is looped from its own hreadyout.
module tb_itrx_amba3_ahblite_regbank_slv;
  localparam int DW = 64;

  logic hclk = 1'b0;
  logic hreset_n = 1'b0;
  always #5 hclk = ~hclk;

  int tgt = 0;
  logic hsel = 1'b0;
  logic [31:0] haddr = '0;
  logic [1:0] htrans = 2'd0;
  logic hwrite = 1'b0;
  logic [2:0] hsize = 3'd0;
  logic [DW-1:0] hwdata = '0;

  int n_chk = 0;
  int n_err = 0;

  itrx_amba3_ahblite_regbank_slv_if #(.HDATAW(DW)) b0 ();
  itrx_amba3_ahblite_regbank_slv_if #(.HDATAW(DW)) b1 ();
  itrx_amba3_ahblite_regbank_slv_if #(.HDATAW(DW)) b2 ();

  assign b0.hsel = hsel && (tgt == 0);
  assign b1.hsel = hsel && (tgt == 1);
  assign b2.hsel = hsel && (tgt == 2);
  assign b0.hready = b0.hreadyout;
  assign b1.hready = b1.hreadyout;
  assign b2.hready = b2.hreadyout;
  assign {b0.haddr, b1.haddr, b2.haddr} = {3{haddr}};
  assign {b0.htrans, b1.htrans, b2.htrans} = {3{htrans}};
  assign {b0.hwrite, b1.hwrite, b2.hwrite} = {3{hwrite}};
  assign {b0.hsize, b1.hsize, b2.hsize} = {3{hsize}};
  assign {b0.hwdata, b1.hwdata, b2.hwdata} = {3{hwdata}};
  assign {b0.hburst, b1.hburst, b2.hburst} = '0;
  assign {b0.hprot, b1.hprot, b2.hprot} = '0;
  assign {b0.hmastlock, b1.hmastlock, b2.hmastlock} = '0;

  itrx_amba3_ahblite_regbank_slv #(.HDATAW(DW), .NWORDS(16), .WAIT(0))
    u0 (.hclk(hclk), .hreset_n(hreset_n), .bus(b0));
  itrx_amba3_ahblite_regbank_slv #(.HDATAW(DW), .NWORDS(16), .WAIT(2))
    u1 (.hclk(hclk), .hreset_n(hreset_n), .bus(b1));
  itrx_amba3_ahblite_regbank_slv #(.HDATAW(DW), .NWORDS(16), .WAIT(3))
    u2 (.hclk(hclk), .hreset_n(hreset_n), .bus(b2));

  logic ro, rsp;
  logic [DW-1:0] rd;
  assign ro  = (tgt == 0) ? b0.hreadyout
             : (tgt == 1) ? b1.hreadyout : b2.hreadyout;
  assign rsp = (tgt == 0) ? b0.hresp
             : (tgt == 1) ? b1.hresp : b2.hresp;
  assign rd  = (tgt == 0) ? b0.hrdata
             : (tgt == 1) ? b1.hrdata : b2.hrdata;

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic addr(input int t, input logic w,
                      input logic [31:0] a, input logic [2:0] sz);
    tgt = t; hsel = 1'b1; htrans = 2'd2;
    hwrite = w; haddr = a; hsize = sz;
  endtask

  task automatic idle();
    hsel = 1'b0; htrans = 2'd0; hwrite = 1'b0;
  endtask

  task automatic test_reset();
    tgt = 0; idle();
    #2;
    n_chk++; if (ro !== 1'b1) begin n_err++; $display("FAIL rst_ready got %b want 1", ro); end
    n_chk++; if (rsp !== 1'b0) begin n_err++; $display("FAIL rst_resp got %b want 0", rsp); end
    n_chk++; if (rd !== '0) begin n_err++; $display("FAIL rst_rdata got %h want 0", rd); end
    repeat (2) tick();
    hreset_n = 1'b1;
    tick(); addr(0, 1'b0, 32'h08, 3'd3);
    tick(); idle(); #1;
    n_chk++; if (rd !== '0) begin n_err++; $display("FAIL rst_read0 got %h want 0", rd); end
    tick(); addr(0, 1'b1, 32'h08, 3'd3);
    tick(); hwdata = 64'h5555AAAA12345678; addr(0, 1'b0, 32'h08, 3'd3);
    tick(); idle(); #1;
    n_chk++; if (rd !== 64'h5555AAAA12345678) begin n_err++; $display("FAIL rst_pre got %h want 5555aaaa12345678", rd); end
    #1 hreset_n = 1'b0;
    #1;
    n_chk++; if (rd !== '0) begin n_err++; $display("FAIL rst_async_rdata got %h want 0", rd); end
    n_chk++; if (ro !== 1'b1 || rsp !== 1'b0) begin n_err++; $display("FAIL rst_async_bus got %b/%b want 1/0", ro, rsp); end
    tick(); hreset_n = 1'b1; hwdata = '0;
    tick(); addr(0, 1'b0, 32'h08, 3'd3);
    tick(); idle(); #1;
    n_chk++; if (rd !== '0) begin n_err++; $display("FAIL rst_after got %h want 0", rd); end
  endtask

  task automatic test_dword();
    tick(); addr(0, 1'b1, 32'h08, 3'd3); #1;
    n_chk++; if (ro !== 1'b1) begin n_err++; $display("FAIL dw_ready_a got %b want 1", ro); end
    tick(); hwdata = 64'h0123456789ABCDEF; addr(0, 1'b0, 32'h08, 3'd3); #1;
    n_chk++; if (ro !== 1'b1 || rsp !== 1'b0) begin n_err++; $display("FAIL dw_wr_phase got %b/%b want 1/0", ro, rsp); end
    tick(); idle(); hwdata = '0; #1;
    n_chk++; if (rd !== 64'h0123456789ABCDEF) begin n_err++; $display("FAIL dw_read got %h want 0123456789abcdef", rd); end
    n_chk++; if (ro !== 1'b1) begin n_err++; $display("FAIL dw_ready_r got %b want 1", ro); end
    tick(); #1;
    n_chk++; if (rd !== '0) begin n_err++; $display("FAIL dw_idle_rdata got %h want 0", rd); end
  endtask

  task automatic test_byte();
    tick(); addr(0, 1'b1, 32'h0B, 3'd0);
    tick(); hwdata = 64'h11111111AA223333; addr(0, 1'b0, 32'h08, 3'd3);
    tick(); hwdata = '0; addr(0, 1'b0, 32'h0A, 3'd1); #1;
    n_chk++; if (rd !== 64'h01234567AAABCDEF) begin n_err++; $display("FAIL byte_write got %h want 01234567aaabcdef", rd); end
    tick(); idle(); #1;
    n_chk++; if (rd !== 64'h01234567AAABCDEF) begin n_err++; $display("FAIL half_read_lanes got %h want 01234567aaabcdef", rd); end
  endtask

  task automatic test_error();
    tick(); addr(0, 1'b0, 32'h80, 3'd3);
    tick(); idle(); #1;
    n_chk++; if (ro !== 1'b0 || rsp !== 1'b1) begin n_err++; $display("FAIL err_range_c1 got %b/%b want 0/1", ro, rsp); end
    n_chk++; if (rd !== '0) begin n_err++; $display("FAIL err_rdata got %h want 0", rd); end
    tick(); #1;
    n_chk++; if (ro !== 1'b1 || rsp !== 1'b1) begin n_err++; $display("FAIL err_range_c2 got %b/%b want 1/1", ro, rsp); end
    tick(); addr(0, 1'b1, 32'h01, 3'd1);
    tick(); hwdata = '1; idle(); #1;
    n_chk++; if (ro !== 1'b0 || rsp !== 1'b1) begin n_err++; $display("FAIL err_align_c1 got %b/%b want 0/1", ro, rsp); end
    addr(0, 1'b0, 32'h00, 3'd3);
    tick(); #1;
    n_chk++; if (ro !== 1'b1 || rsp !== 1'b1) begin n_err++; $display("FAIL err_align_c2 got %b/%b want 1/1", ro, rsp); end
    tick(); hwdata = '0; addr(0, 1'b0, 32'h78, 3'd3); #1;
    n_chk++; if (ro !== 1'b1 || rsp !== 1'b0 || rd !== '0) begin n_err++; $display("FAIL err_no_write got %b/%b/%h want 1/0/0", ro, rsp, rd); end
    tick(); addr(0, 1'b0, 32'h00, 3'd4); #1;
    n_chk++; if (rsp !== 1'b0 || rd !== '0) begin n_err++; $display("FAIL top_word got %b/%h want 0/0", rsp, rd); end
    tick(); idle(); #1;
    n_chk++; if (ro !== 1'b0 || rsp !== 1'b1) begin n_err++; $display("FAIL err_size_c1 got %b/%b want 0/1", ro, rsp); end
    tick(); #1;
    n_chk++; if (ro !== 1'b1 || rsp !== 1'b1) begin n_err++; $display("FAIL err_size_c2 got %b/%b want 1/1", ro, rsp); end
    tick(); #1;
    n_chk++; if (ro !== 1'b1 || rsp !== 1'b0) begin n_err++; $display("FAIL err_recover got %b/%b want 1/0", ro, rsp); end
  endtask

  task automatic test_wait();
    tick(); addr(1, 1'b1, 32'h00, 3'd3);
    tick(); hwdata = 64'hDEADBEEF00000001; addr(1, 1'b0, 32'h00, 3'd3); #1;
    n_chk++; if (ro !== 1'b0) begin n_err++; $display("FAIL wt_wr_w1 got %b want 0", ro); end
    tick(); #1;
    n_chk++; if (ro !== 1'b0) begin n_err++; $display("FAIL wt_wr_w2 got %b want 0", ro); end
    tick(); #1;
    n_chk++; if (ro !== 1'b1 || rsp !== 1'b0) begin n_err++; $display("FAIL wt_wr_done got %b/%b want 1/0", ro, rsp); end
    tick(); idle(); hwdata = '0; #1;
    n_chk++; if (ro !== 1'b0 || rd !== '0) begin n_err++; $display("FAIL wt_rd_w1 got %b/%h want 0/0", ro, rd); end
    tick(); #1;
    n_chk++; if (ro !== 1'b0) begin n_err++; $display("FAIL wt_rd_w2 got %b want 0", ro); end
    tick(); #1;
    n_chk++; if (ro !== 1'b1 || rd !== 64'hDEADBEEF00000001) begin n_err++; $display("FAIL wt_rd_done got %b/%h want 1/deadbeef00000001", ro, rd); end
    tick(); #1;
    n_chk++; if (ro !== 1'b1 || rd !== '0) begin n_err++; $display("FAIL wt_after got %b/%h want 1/0", ro, rd); end
  endtask

  task automatic test_reset_wait();
    tick(); addr(2, 1'b1, 32'h10, 3'd3);
    tick(); hwdata = 64'hCAFEF00D12345678; idle(); #1;
    n_chk++; if (ro !== 1'b0) begin n_err++; $display("FAIL rw_w1 got %b want 0", ro); end
    tick(); #1;
    n_chk++; if (ro !== 1'b0) begin n_err++; $display("FAIL rw_w2 got %b want 0", ro); end
    #1 hreset_n = 1'b0;
    #1;
    n_chk++; if (ro !== 1'b1 || rsp !== 1'b0) begin n_err++; $display("FAIL rw_async got %b/%b want 1/0", ro, rsp); end
    tick(); hreset_n = 1'b1;
    tick();
    tick(); hwdata = '0; addr(2, 1'b0, 32'h10, 3'd3);
    tick(); idle(); #1;
    n_chk++; if (ro !== 1'b0) begin n_err++; $display("FAIL rw_rd_w1 got %b want 0", ro); end
    tick(); tick(); #1;
    n_chk++; if (ro !== 1'b0) begin n_err++; $display("FAIL rw_rd_w3 got %b want 0", ro); end
    tick(); #1;
    n_chk++; if (ro !== 1'b1 || rd !== '0) begin n_err++; $display("FAIL rw_rd_done got %b/%h want 1/0", ro, rd); end
  endtask

  initial begin
    test_reset();
    test_dword();
    test_byte();
    test_error();
    test_wait();
    test_reset_wait();
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "timeout");
  end
endmodule
